// File: rtl/instr_loader.sv
// instr_loader: fills the 16-bit instruction memory from a big-endian byte
// stream. Two bytes are assembled per word, written once, and summed into a
// running mod-2^16 checksum. The control unit stalls on busy while loading.
module instr_loader #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] count,
    input  logic          abort,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [15:0]   checksum
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HI   = 3'd1,
        S_LO   = 3'd2,
        S_WR   = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_remain;
    logic [7:0]    r_hi;
    logic [DW-1:0] r_data;
    logic [15:0]   r_checksum;
    logic          r_err;
    logic          w_last;

    assign w_last   = (r_remain == AW'(1));
    assign wr_addr  = r_addr;
    assign wr_data  = r_data;
    assign checksum = r_checksum;
    assign err      = r_err;

    // State register; reset drops every strobe decoded from state at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and strobe decode; abort suppresses the write in WR.
    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        wr_en    = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = (count != '0) ? S_HI : S_FIN;
                end
            end
            S_HI: begin
                in_ready = 1'b1;
                if (abort) begin
                    w_next = S_IDLE;
                end else if (in_valid) begin
                    w_next = S_LO;
                end
            end
            S_LO: begin
                in_ready = 1'b1;
                if (abort) begin
                    w_next = S_IDLE;
                end else if (in_valid) begin
                    w_next = S_WR;
                end
            end
            S_WR: begin
                wr_en = ~abort;
                if (abort) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = w_last ? S_FIN : S_HI;
                end
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: latch load parameters, assemble words, advance address and sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr     <= '0;
            r_remain   <= '0;
            r_hi       <= '0;
            r_data     <= '0;
            r_checksum <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr     <= base;
                        r_remain   <= count;
                        r_checksum <= '0;
                        r_err      <= 1'b0;
                    end
                end
                S_HI: begin
                    if (abort) begin
                        r_err <= 1'b1;
                    end else if (in_valid) begin
                        r_hi <= in_data;
                    end
                end
                S_LO: begin
                    if (abort) begin
                        r_err <= 1'b1;
                    end else if (in_valid) begin
                        r_data <= DW'({r_hi, in_data});
                    end
                end
                S_WR: begin
                    if (abort) begin
                        r_err <= 1'b1;
                    end else begin
                        r_checksum <= r_checksum + 16'(r_data);
                        r_addr     <= r_addr + AW'(1);
                        r_remain   <= r_remain - AW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized loads checked against a word-list model built
// from base/count/byte stream, plus directed corner cases.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] base;
    logic [15:0] count;
    logic        abort;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] checksum;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] fixed_bytes[$];

    instr_loader #(.AW(16), .DW(16)) dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .count(count),
        .abort(abort), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .err(err),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete load: source model drives bytes, monitor collects writes.
    task automatic do_load(input string tag, input logic [15:0] b, input logic [15:0] c,
                           input bit throttle, input int abort_byte,
                           input bit poke_start, input bit fin_abort);
        logic [7:0]  bytes[$];
        logic [15:0] exp_addr[$];
        logic [15:0] exp_data[$];
        logic [15:0] got_addr[$];
        logic [15:0] got_data[$];
        logic [15:0] exp_sum;
        int nwords, idx, n_done, busy_cyc, first_ready, done_cyc, ready_in_wr;
        bit ended, abort_hit, last_wr_seen;

        if (fixed_bytes.size() != 0) begin
            bytes = fixed_bytes;
            fixed_bytes.delete();
        end else begin
            for (int i = 0; i < 2 * int'(c); i++) bytes.push_back(8'($urandom));
        end
        nwords  = (abort_byte >= 0) ? abort_byte / 2 : int'(c);
        exp_sum = 16'h0;
        for (int i = 0; i < nwords; i++) begin
            exp_addr.push_back(b + 16'(i));
            exp_data.push_back({bytes[2*i], bytes[2*i+1]});
            exp_sum = exp_sum + {bytes[2*i], bytes[2*i+1]};
        end

        @(posedge clk); #1;
        start = 1'b1; base = b; count = c; in_valid = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; base = 16'($urandom); count = 16'($urandom);

        idx = 0; n_done = 0; busy_cyc = 0; first_ready = -1; done_cyc = -1;
        ready_in_wr = 0; ended = 1'b0; abort_hit = 1'b0; last_wr_seen = 1'b0;
        for (int cyc = 0; cyc < 2000 && !ended; cyc++) begin
            in_valid = throttle ? ($urandom_range(0, 2) == 0) : 1'b1;
            in_data  = (idx < bytes.size()) ? bytes[idx] : 8'($urandom);
            abort    = (abort_byte >= 0 && idx == abort_byte && in_ready) ||
                       (fin_abort && last_wr_seen && busy && !in_ready);
            if (abort && in_ready) in_valid = 1'b1;
            if (poke_start && idx == 1 && in_ready) begin
                start = 1'b1;
                base  = b + 16'h0100;
            end
            @(negedge clk);
            if (busy) busy_cyc++;
            if (wr_en) begin
                got_addr.push_back(wr_addr);
                got_data.push_back(wr_data);
                if (idx == 2 * int'(c)) last_wr_seen = 1'b1;
            end
            if (wr_en && in_ready) ready_in_wr++;
            if (in_ready && first_ready < 0) first_ready = cyc;
            if (done) begin n_done++; done_cyc = cyc; end
            if (abort && in_ready) abort_hit = 1'b1;
            if (in_valid && in_ready && !abort) idx++;
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0;
            if (abort_hit || done_cyc >= 0) ended = 1'b1;
        end
        if (!ended) check_eq({tag, "_timeout"}, 32'd0, 32'd1);

        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) n_done++;
            if (wr_en) begin
                got_addr.push_back(wr_addr);
                got_data.push_back(wr_data);
            end
        end
        @(posedge clk); #1;

        check_eq({tag, "_nwrites"}, got_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check_eq({tag, "_addr"}, got_addr[i], exp_addr[i]);
            check_eq({tag, "_data"}, got_data[i], exp_data[i]);
        end
        check_eq({tag, "_checksum"}, checksum, exp_sum);
        check_eq({tag, "_err"}, err, (abort_byte >= 0) ? 1 : 0);
        check_eq({tag, "_ndone"}, n_done, (abort_byte >= 0) ? 0 : 1);
        check_eq({tag, "_consumed"}, idx, (abort_byte >= 0) ? abort_byte : 2 * int'(c));
        check_eq({tag, "_ready_in_wr"}, ready_in_wr, 0);
        check_eq({tag, "_idle_busy"}, busy, 0);
        if (!throttle && abort_byte < 0) begin
            check_eq({tag, "_busy_cycles"}, busy_cyc, 3 * int'(c) + 1);
            check_eq({tag, "_done_cycle"}, done_cyc, 3 * int'(c));
            check_eq({tag, "_first_ready"}, first_ready, (c == 16'h0) ? -1 : 0);
        end
    endtask

    initial begin
        int wait_cnt;
        int stray;
        reset = 1'b1; start = 1'b0; base = '0; count = '0; abort = 1'b0;
        in_data = '0; in_valid = 1'b0;
        #12;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_wr_en", wr_en, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_addr", wr_addr, 0);
        check_eq("rst_data", wr_data, 0);
        check_eq("rst_checksum", checksum, 0);
        @(negedge clk); reset = 1'b0;

        fixed_bytes = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        do_load("basic", 16'h0010, 16'd2, 1'b0, -1, 1'b0, 1'b0);
        check_eq("basic_sum_const", checksum, 16'hBE01);

        fixed_bytes = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        do_load("throttled", 16'h0010, 16'd2, 1'b1, -1, 1'b0, 1'b0);

        fixed_bytes = '{8'h00, 8'h01, 8'hFF, 8'hFF};
        do_load("wrap", 16'hFFFF, 16'd2, 1'b0, -1, 1'b0, 1'b0);
        check_eq("wrap_sum_const", checksum, 16'h0000);

        do_load("zero", 16'h1234, 16'd0, 1'b0, -1, 1'b0, 1'b0);

        fixed_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        do_load("abort", 16'h0200, 16'd3, 1'b0, 3, 1'b0, 1'b0);
        check_eq("abort_err_sticky", err, 1);

        do_load("after_abort", 16'h0300, 16'd1, 1'b0, -1, 1'b0, 1'b0);
        do_load("start_busy", 16'h0400, 16'd3, 1'b0, -1, 1'b1, 1'b0);
        do_load("fin_abort", 16'h0500, 16'd2, 1'b1, -1, 1'b0, 1'b1);

        // Asynchronous reset while a write is on the port.
        @(posedge clk); #1;
        start = 1'b1; base = 16'h0040; count = 16'd2;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = 8'($urandom);
        wait_cnt = 0;
        do begin
            @(negedge clk);
            wait_cnt++;
        end while (!wr_en && wait_cnt < 20);
        check_eq("rst_mid_reached_wr", wr_en, 1);
        #2 reset = 1'b1;
        #1;
        check_eq("rst_mid_wr_en", wr_en, 0);
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_in_ready", in_ready, 0);
        check_eq("rst_mid_done", done, 0);
        check_eq("rst_mid_addr", wr_addr, 0);
        check_eq("rst_mid_data", wr_data, 0);
        check_eq("rst_mid_checksum", checksum, 0);
        @(negedge clk); reset = 1'b0;
        stray = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (wr_en || busy) stray++;
        end
        check_eq("rst_mid_no_writes", stray, 0);
        in_valid = 1'b0;
        do_load("after_reset", 16'h0040, 16'd2, 1'b0, -1, 1'b0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            logic [15:0] rc;
            int ab;
            rc = 16'($urandom_range(0, 5));
            ab = -1;
            if (rc != 16'h0 && $urandom_range(0, 3) == 0) ab = $urandom_range(0, 2 * int'(rc) - 1);
            do_load("rand", 16'($urandom), rc, 1'($urandom), ab, 1'($urandom), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Program loader that fills the control unit's 16-bit instruction memory from an 8-bit byte stream. It is the write side of the instruction-memory port that the control unit reads through `pc`. It replaces the `$readmemh` preload path for hardware bring-up. While the loader is busy, the control unit holds `pc` and issues no instructions.

## Interface
Parameters:
- `AW`, 16: instruction-memory address width.
- `DW`, 16: instruction word width. Fixed at 2 bytes; other values are unsupported.

Ports:
- `clk`  in  1  sole clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a load. Sampled only in IDLE.
- `base`  in  AW  first word address. Latched on an accepted `start`.
- `count`  in  AW  number of words to load. Latched on an accepted `start`.
- `abort`  in  1  synchronous cancel of a load in progress.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `wr_en`  out  1  instruction-memory write strobe.
- `wr_addr`  out  AW  write address.
- `wr_data`  out  DW  write data.
- `busy`  out  1  load in progress; the control unit stalls on this.
- `done`  out  1  one-cycle pulse when a load completes.
- `err`  out  1  sticky flag: last load was aborted.
- `checksum`  out  16  mod-2^16 sum of the words written by the current or last load.

## Operation
State machine: IDLE, HI, LO, WR, FIN.

- **IDLE**
  - An accepted `start` latches `base` into the address register and `count` into the remaining-word register.
  - The same edge clears `checksum` and `err`.
  - Next state is HI if `count != 0`, otherwise FIN.
  - `start` in any state other than IDLE is ignored.
- **HI**
  - `in_ready = 1`.
  - On `in_valid & in_ready`, `in_data` goes into word bits [15:8]; next state is LO.
  - Bytes are big-endian: high byte first.
- **LO**
  - `in_ready = 1`.
  - On the handshake, `in_data` goes into bits [7:0]; next state is WR.
- **WR**
  - `wr_en = 1` for exactly one cycle, with `wr_addr` = current address and `wr_data` = the assembled word.
  - At the end of the cycle: `checksum += word`, address increments, remaining decrements.
  - Next state is FIN if remaining was 1, otherwise HI.
- **FIN**
  - `done = 1` for one cycle; next state is IDLE.
- **`busy`** is 1 in HI, LO, WR and FIN, and 0 in IDLE.
- **`in_ready`** is combinational from state: 1 only in HI and LO, and 0 in WR, FIN and IDLE. `in_valid` is ignored in those three states and no byte is consumed.
- **`wr_addr`, `wr_data`** are registered. `wr_data` holds its last value when `wr_en = 0`.
- **Address arithmetic** is AW bits wide, so an address of 2^AW−1 increments to 0 (wrap-around). A `count` of 2^AW−1 starting at 0 writes every address except the last.
- **Checksum** is a 16-bit add with the carry discarded.
- **`abort`**
  - In HI, LO or WR, `abort` moves to IDLE on that edge and sets `err = 1`. No write occurs, `done` is not pulsed, and any partial word is discarded.
  - `abort` takes priority over a simultaneous byte handshake: that byte counts as not consumed. The source must not count it as accepted, since `in_ready` is combinational.
  - `abort` in FIN is ignored; the load completes.
  - `abort` in IDLE is ignored.
- **`reset`** is asserted asynchronously and is allowed at any time, including mid-load.
  - State → IDLE.
  - `in_ready`, `wr_en`, `busy`, `done` and `err` → 0.
  - `wr_addr`, `wr_data`, `checksum` and the internal counters → 0.
  - A partial word is discarded and no write is issued during or after reset.

## Timing
- Zero-stall throughput is 3 cycles per word: HI, LO, WR.
- If `start` is accepted at edge E, `in_ready` is first high in the cycle after E.
- Last low byte accepted at edge N:
  - `wr_en` is high in cycle N..N+1.
  - `done` is high in cycle N+1..N+2.
  - `busy` falls at edge N+2.
- `count = 0`: `done` pulses in the cycle after the accepting edge, with no write, no `in_ready`, and `checksum = 0`.
- `start` asserted in the same cycle as `done` is ignored, because state is FIN. The earliest new start is accepted in IDLE, one cycle after `done`.
- Source stalls (`in_valid = 0`) hold the state indefinitely; there is no timeout.

## Test plan
- **Basic load.** `base=0x0010`, `count=2`, bytes 0x12,0x34,0xAB,0xCD with `in_valid` held high → writes (0x0010, 0x1234) and (0x0011, 0xABCD), `checksum=0xBE01`, `done` pulses exactly 1 cycle, and `busy` spans 7 cycles after `start`.
- **Throttled source.** Same load as the basic case with `in_valid` toggling 1,0,0,1… → identical writes in the same order, `in_ready` never 1 in WR, and no byte is duplicated or dropped.
- **Wrap and zero count.**
  - `base=0xFFFF`, `count=2`, bytes 0x00,0x01,0xFF,0xFF → writes (0xFFFF, 0x0001) and (0x0000, 0xFFFF), `checksum=0x0000`.
  - Then `count=0` → `done` one cycle after `start`, no `wr_en`, `checksum=0`.
- **Abort mid-word.** `count=3`; after 0x11,0x22,0x33, assert `abort` together with a valid 0x44 in LO → one write (base, 0x1122), `err=1`, no `done`, and 0x44 is not consumed. The next `start` clears `err`.
- **Reset mid-load.** Assert `reset` asynchronously during WR, between clock edges → `wr_en` drops immediately, all outputs are 0, and no further writes occur. After release, a fresh `start` loads correctly.
- **Start while busy.** Pulse `start` with a different `base` during LO → ignored; the original load completes at the original addresses.
